// File: rtl/prio_arb_rr.sv
// Registered N-input priority arbiter: fixed priority (highest index wins) or
// round-robin, holding each grant until it is acknowledged.
module prio_arb_rr #(
    parameter int N  = 8,
    parameter int W  = $clog2(N),
    parameter bit RR = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [N-1:0] ONE  = N'(1);

    state_t       state, state_nx;
    logic [W-1:0] ptr, ptr_nx;
    logic [W-1:0] idx_nx;
    logic [N-1:0] oh_nx;
    logic [N-1:0] cand;
    logic [W-1:0] win;
    logic         any;
    logic         found;

    // The just-served requester sits out the back-to-back decision.
    always_comb begin
        cand = (state == GRANT) ? (req & ~gnt_onehot) : req;
        any  = |cand;
    end

    // Round-robin walks downward from ptr, wrapping modulo N (not 2^W).
    always_comb begin
        win   = '0;
        found = 1'b0;
        if (RR) begin
            for (int unsigned k = 0; k < N; k++) begin
                int unsigned pos;
                pos = (int'(ptr) >= int'(k)) ? int'(ptr) - k : int'(ptr) + N - k;
                if (!found && cand[pos]) begin
                    found = 1'b1;
                    win   = W'(pos);
                end
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (cand[k]) begin
                    win = W'(k);
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        idx_nx   = gnt_idx;
        oh_nx    = gnt_onehot;
        case (state)
            IDLE: begin
                if (any) begin
                    state_nx = GRANT;
                    idx_nx   = win;
                    oh_nx    = ONE << win;
                end
            end
            GRANT: begin
                if (ack) begin
                    ptr_nx = (gnt_idx == '0) ? LAST : gnt_idx - W'(1);
                    if (any) begin
                        idx_nx = win;
                        oh_nx  = ONE << win;
                    end else begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        oh_nx    = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= LAST;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            gnt_idx    <= idx_nx;
            gnt_onehot <= oh_nx;
        end
    end

    assign gnt_valid = (state == GRANT);

endmodule

// File: tb/tb_prio_arb_rr.sv
// Directed bench for prio_arb_rr: fixed N=8, round-robin N=8 and round-robin N=5.
module tb_prio_arb_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] req_f, req_r;
    logic [4:0] req_5;
    logic       ack_f, ack_r, ack_5;
    logic       vld_f, vld_r, vld_5;
    logic [2:0] idx_f, idx_r, idx_5;
    logic [7:0] oh_f, oh_r;
    logic [4:0] oh_5;

    int n_checks = 0;
    int n_pass   = 0;

    prio_arb_rr #(.N(8), .RR(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req_f), .ack(ack_f),
        .gnt_valid(vld_f), .gnt_idx(idx_f), .gnt_onehot(oh_f)
    );

    prio_arb_rr #(.N(8), .RR(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req_r), .ack(ack_r),
        .gnt_valid(vld_r), .gnt_idx(idx_r), .gnt_onehot(oh_r)
    );

    prio_arb_rr #(.N(5), .RR(1'b1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .req(req_5), .ack(ack_5),
        .gnt_valid(vld_5), .gnt_idx(idx_5), .gnt_onehot(oh_5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] single_req [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h88};
    int         single_idx [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int         fix_seq    [3] = '{6, 7, 6};
    int         rr_seq     [8] = '{6, 5, 4, 3, 2, 1, 0, 7};
    int         rr5_seq    [3] = '{2, 0, 4};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req_f = '0; req_r = '0; req_5 = '0;
        ack_f = 1'b0; ack_r = 1'b0; ack_5 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vld_f", vld_f, 0);
        check("rst_idx_f", idx_f, 0);
        check("rst_oh_f",  oh_f,  0);
        check("rst_vld_r", vld_r, 0);
        check("rst_oh_5",  oh_5,  0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed mode: single requests, each released by an ack with req=0.
        for (int i = 0; i < 9; i++) begin
            req_f = single_req[i];
            ack_f = 1'b0;
            @(negedge clk);
            check("single_vld", vld_f, 1);
            check("single_idx", idx_f, single_idx[i]);
            check("single_oh",  oh_f,  32'd1 << single_idx[i]);
            req_f = '0;
            ack_f = 1'b1;
            @(negedge clk);
            check("single_rel_vld", vld_f, 0);
            check("single_rel_idx", idx_f, 0);
        end
        ack_f = 1'b0;

        // Hold: grant is frozen while req changes without ack.
        req_f = 8'h88;
        @(negedge clk);
        check("hold_first", idx_f, 7);
        req_f = 8'h08;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_idx", idx_f, 7);
            check("hold_oh",  oh_f,  8'h80);
        end
        ack_f = 1'b1;
        @(negedge clk);
        check("hold_next_idx", idx_f, 3);
        check("hold_next_oh",  oh_f,  8'h08);
        req_f = '0;
        @(negedge clk);
        check("hold_end_vld", vld_f, 0);
        ack_f = 1'b0;

        // Fixed mode alternates between the top two under full load.
        req_f = 8'hFF;
        @(negedge clk);
        check("fix_ff_first", idx_f, 7);
        ack_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fix_ff_idx", idx_f, fix_seq[i]);
            check("fix_ff_vld", vld_f, 1);
        end
        req_f = '0;
        @(negedge clk);
        check("fix_ff_end", vld_f, 0);
        ack_f = 1'b0;

        // Round-robin N=8 under full load, no bubbles.
        req_r = 8'hFF;
        @(negedge clk);
        check("rr_first", idx_r, 7);
        ack_r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_idx", idx_r, rr_seq[i]);
            check("rr_vld", vld_r, 1);
            check("rr_oh",  oh_r,  32'd1 << rr_seq[i]);
        end
        ack_r = 1'b0;

        // Round-robin N=5: ack in IDLE ignored, then wrap modulo 5.
        ack_5 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rr5_idle_ack", vld_5, 0);
        end
        ack_5 = 1'b0;
        req_5 = 5'b10101;
        @(negedge clk);
        check("rr5_first", idx_5, 4);
        ack_5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rr5_idx",   idx_5, rr5_seq[i]);
            check("rr5_range", idx_5 < 3'd5, 1);
            check("rr5_oh",    oh_5,  32'd1 << rr5_seq[i]);
        end
        ack_5 = 1'b0;
        @(negedge clk);

        // Asynchronous reset between edges while u_rr holds a grant.
        check("pre_rst_vld_r", vld_r, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_vld_r", vld_r, 0);
        check("async_idx_r", idx_r, 0);
        check("async_oh_r",  oh_r,  0);
        check("async_vld_5", vld_5, 0);
        @(negedge clk);
        req_5 = '0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idx_r", idx_r, 7);
        check("post_rst_vld_r", vld_r, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
